gteq_serial_cmp: RTL and testbench

- Parametrised, multi-cycle magnitude comparator; successor to the fixed 8-bit combinational `>=` block.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, with early exit on the first differing digit.
- Supports signed and unsigned modes and reports greater-than, equal, less-than and greater-or-equal.
- Sits beside datapath blocks as a low-area comparator with a start/busy/done handshake.

---
 rtl/gteq_serial_cmp.sv | 137 +++++++++++++
 tb/tb_gteq_serial_cmp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gteq_serial_cmp.sv
// rtl/gteq_serial_cmp.sv - multi-cycle MSB-first magnitude comparator, DIGIT bits per clock
// Signed operands are mapped to offset binary at capture so the digit walk is always unsigned.
module gteq_serial_cmp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agtb,
  output logic             aeqb,
  output logic             altb,
  output logic             agteqb
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {
    S_IDLE,
    S_COMPARE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             agtb_q, agtb_d;
  logic             aeqb_q, aeqb_d;
  logic             altb_q, altb_d;
  logic             agteqb_q, agteqb_d;

  logic [DIGIT-1:0] top_a;
  logic [DIGIT-1:0] top_b;
  logic             top_gt;

  assign top_a  = a_sr_q[WIDTH-1 -: DIGIT];
  assign top_b  = b_sr_q[WIDTH-1 -: DIGIT];
  assign top_gt = (top_a > top_b);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    agtb_d   = agtb_q;
    aeqb_d   = aeqb_q;
    altb_d   = altb_q;
    agteqb_d = agteqb_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d = a;
          b_sr_d = b;
          if (signed_mode) begin
            a_sr_d[WIDTH-1] = ~a[WIDTH-1];
            b_sr_d[WIDTH-1] = ~b[WIDTH-1];
          end
          cnt_d   = CW'(NDIG - 1);
          busy_d  = 1'b1;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (top_a != top_b) begin
          agtb_d   = top_gt;
          altb_d   = ~top_gt;
          aeqb_d   = 1'b0;
          agteqb_d = top_gt;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (cnt_q == '0) begin
          agtb_d   = 1'b0;
          altb_d   = 1'b0;
          aeqb_d   = 1'b1;
          agteqb_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          a_sr_d = a_sr_q << DIGIT;
          b_sr_d = b_sr_q << DIGIT;
          cnt_d  = cnt_q - CW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      agtb_q   <= 1'b0;
      aeqb_q   <= 1'b0;
      altb_q   <= 1'b0;
      agteqb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      agtb_q   <= agtb_d;
      aeqb_q   <= aeqb_d;
      altb_q   <= altb_d;
      agteqb_q <= agteqb_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign agtb   = agtb_q;
  assign aeqb   = aeqb_q;
  assign altb   = altb_q;
  assign agteqb = agteqb_q;

endmodule

// File: tb/tb_gteq_serial_cmp.sv
// tb/tb_gteq_serial_cmp.sv - directed and randomised checks of gteq_serial_cmp at three geometries
module tb_gteq_serial_cmp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 16/4 instance for directed tests
  logic        st16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, agtb16, aeqb16, altb16, agteqb16;

  // 8/1 and 32/8 instances for the sweep
  logic        st8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, agtb8, aeqb8, altb8, agteqb8;

  logic        st32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, agtb32, aeqb32, altb32, agteqb32;

  gteq_serial_cmp #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .agtb(agtb16), .aeqb(aeqb16), .altb(altb16), .agteqb(agteqb16)
  );

  gteq_serial_cmp #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .agtb(agtb8), .aeqb(aeqb8), .altb(altb8), .agteqb(agteqb8)
  );

  gteq_serial_cmp #(.WIDTH(32), .DIGIT(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .signed_mode(sm32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .agtb(agtb32), .aeqb(aeqb32), .altb(altb32), .agteqb(agteqb32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {agtb, aeqb, altb, agteqb}
  function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input bit sm);
    longint la, lb;
    la = longint'(a);
    lb = longint'(b);
    if (sm && a[w-1]) la = la - (longint'(1) << w);
    if (sm && b[w-1]) lb = lb - (longint'(1) << w);
    return {la > lb, la == lb, la < lb, la >= lb};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                 input int w, input int d);
    logic [31:0] dm;
    int nd;
    nd = w / d;
    dm = (d >= 32) ? 32'hFFFF_FFFF : ((32'd1 << d) - 32'd1);
    for (int i = 0; i < nd; i++) begin
      if (((a >> (w - (i + 1) * d)) & dm) != ((b >> (w - (i + 1) * d)) & dm)) return i + 1;
    end
    return nd;
  endfunction

  function automatic logic [3:0] flags16();
    return {agtb16, aeqb16, altb16, agteqb16};
  endfunction

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       output int lat, output int busy_cyc);
    @(posedge clk); #1;
    a16 = a; b16 = b; sm16 = sm; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    busy_cyc = busy16 ? 1 : 0;
    lat = 0;
    repeat (40) begin
      @(posedge clk); #1;
      lat++;
      if (done16) break;
      if (busy16) busy_cyc++;
    end
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input int exp_lat, input logic [3:0] exp_flags);
    int lat, bc;
    run16(a, b, sm, lat, bc);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_flags"}, flags16(), exp_flags);
  endtask

  task automatic random_pair(input int w, output logic [31:0] a, output logic [31:0] b);
    logic [31:0] mask;
    int mode;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a = $urandom() & mask;
    mode = $urandom_range(0, 3);
    if (mode == 0) b = a;
    else if (mode == 1) b = a ^ (32'd1 << $urandom_range(0, w - 1));
    else b = $urandom() & mask;
  endtask

  task automatic sweep8();
    logic [31:0] a, b;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      for (int s = 0; s < 2; s++) begin
        random_pair(8, a, b);
        @(posedge clk); #1;
        a8 = a[7:0]; b8 = b[7:0]; sm8 = s[0]; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        lat = 0;
        repeat (20) begin
          @(posedge clk); #1;
          lat++;
          if (done8) break;
        end
        chk("sweep8_flags", {agtb8, aeqb8, altb8, agteqb8}, ref_flags(a, b, 8, s[0]));
        chk("sweep8_lat", lat, ref_lat(a, b, 8, 1));
      end
    end
  endtask

  task automatic sweep32();
    logic [31:0] a, b;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      for (int s = 0; s < 2; s++) begin
        random_pair(32, a, b);
        @(posedge clk); #1;
        a32 = a; b32 = b; sm32 = s[0]; st32 = 1'b1;
        @(posedge clk); #1;
        st32 = 1'b0;
        lat = 0;
        repeat (20) begin
          @(posedge clk); #1;
          lat++;
          if (done32) break;
        end
        chk("sweep32_flags", {agtb32, aeqb32, altb32, agteqb32}, ref_flags(a, b, 32, s[0]));
        chk("sweep32_lat", lat, ref_lat(a, b, 32, 8));
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc, n_done;
    logic [3:0] hs_flags;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy16, 1'b0);
    chk("reset_done", done16, 1'b0);
    chk("reset_flags", flags16(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal operands: full NDIG walk, busy for exactly 4 cycles, single-cycle done
    run16(16'hAAAA, 16'hAAAA, 1'b0, lat, bc);
    chk("eq_lat", lat, 4);
    chk("eq_busy_cycles", bc, 4);
    chk("eq_flags", flags16(), 4'b0101);
    chk("eq_busy_at_done", busy16, 1'b0);
    @(posedge clk); #1;
    chk("eq_done_one_cycle", done16, 1'b0);
    chk("eq_flags_hold", flags16(), 4'b0101);

    directed("early_gt", 16'hC000, 16'hB000, 1'b0, 1, 4'b1001);
    directed("late_lt", 16'h000C, 16'h000D, 1'b0, 4, 4'b0010);
    directed("signed_neg1", 16'hFFFF, 16'h0001, 1'b1, 1, 4'b0010);
    directed("unsigned_ffff", 16'hFFFF, 16'h0001, 1'b0, 1, 4'b1001);
    directed("signed_min_max", 16'h8000, 16'h7FFF, 1'b1, 1, 4'b0010);
    directed("unsigned_min_max", 16'h8000, 16'h7FFF, 1'b0, 1, 4'b1001);
    directed("digit3_gt", 16'h12F4, 16'h12E9, 1'b0, 3, 4'b1001);

    // Start and operand changes while busy must not disturb the running compare
    @(posedge clk); #1;
    a16 = 16'h1234; b16 = 16'h1235; sm16 = 1'b0; st16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h0000; b16 = 16'hFFFF; sm16 = 1'b1;
    n_done = 0;
    lat = 0;
    hs_flags = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 2) st16 = 1'b0;
      if (done16) begin
        n_done++;
        lat = i;
        hs_flags = flags16();
      end
    end
    chk("hs_done_count", n_done, 1);
    chk("hs_lat", lat, 4);
    chk("hs_flags", hs_flags, 4'b0010);
    // Start issued in the done cycle is captured on the very next edge
    a16 = 16'hC000; b16 = 16'hB000; sm16 = 1'b0; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    chk("b2b_busy", busy16, 1'b1);
    chk("b2b_no_extra_done", done16, 1'b0);
    @(posedge clk); #1;
    chk("b2b_done", done16, 1'b1);
    chk("b2b_flags", flags16(), 4'b1001);

    // Asynchronous reset in the second COMPARE cycle
    @(posedge clk); #1;
    a16 = 16'hAAAA; b16 = 16'hAAAA; sm16 = 1'b0; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy16, 1'b0);
    chk("rst_mid_done", done16, 1'b0);
    chk("rst_mid_flags", flags16(), 4'b0000);
    n_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done16) n_done++;
    end
    chk("rst_mid_no_done", n_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    directed("post_rst", 16'hFFFF, 16'h0000, 1'b0, 1, 4'b1001);

    sweep8();
    sweep32();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
